pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Single pipeline register stage with valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_SKID_EN to build the two-entry skid variant whose in_ready is a pure register output.
`timescale 1ns/1ps
module pipe_stage_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_out_free;
  logic             w_stall;
  logic             w_in_xfer;
  logic             w_out_load;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_out_src;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_stall    = r_out_valid && !out_ready;
  assign w_in_xfer  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;
  logic             w_skid_load;
  logic             w_skid_valid_nxt;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_out_load       = 1'b0;
    w_out_src        = in_data;
    w_out_valid_nxt  = r_out_valid;
    w_skid_load      = 1'b0;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // Oldest payload sits in the skid entry, so it moves forward first.
        w_out_load       = 1'b1;
        w_out_src        = r_skid_data;
        w_out_valid_nxt  = 1'b1;
        w_skid_load      = w_in_xfer;
        w_skid_valid_nxt = w_in_xfer;
      end else if (w_in_xfer) begin
        w_out_load      = 1'b1;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_in_xfer) begin
      w_skid_load      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_skid_load) r_skid_data <= in_data;
    end
  end

  assign in_ready = r_in_ready;
`else
  always_comb begin
    w_out_load      = 1'b0;
    w_out_src       = in_data;
    w_out_valid_nxt = r_out_valid;
    if (flush) begin
      w_out_valid_nxt = 1'b0;
    end else if (w_in_xfer) begin
      w_out_load      = 1'b1;
      w_out_valid_nxt = 1'b1;
    end else if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  // Gated by rst_n so the stage never advertises space while held in reset.
  assign in_ready = rst_n && w_out_free;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, because out_data must read 0 during reset.
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
      r_out_valid <= w_out_valid_nxt;
      if (w_out_load) r_out_data <= w_out_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then randomized traffic against a queue model.
// Compile with PIPE_SKID_EN defined to exercise the skid variant.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ordered list of payloads held by the stage, plus counters.
  logic [WIDTH-1:0] q[$];
  int               m_stall;
  logic [WIDTH-1:0] m_last;
  bit               m_first;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_stall = 0;
    m_last  = '0;
  endtask

  function automatic logic exp_in_ready(input logic ordy);
`ifdef PIPE_SKID_EN
    return m_first ? 1'b0 : (q.size() < 2);
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  // One cycle: called just after a falling edge, returns just after the next falling edge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
    logic ir_e, ixf, oxf, stl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    ir_e = exp_in_ready(ordy);
    check("in_ready", in_ready, ir_e);
    ixf = iv && ir_e;
    oxf = ordy && (q.size() > 0);
    stl = (q.size() > 0) && !ordy;
    @(posedge clk);
    if (stl && m_stall < SAT) m_stall++;
    if (fl) q.delete();
    else begin
      if (oxf) void'(q.pop_front());
      if (ixf) q.push_back(d);
    end
    m_first = 1'b0;
    if (q.size() > 0) m_last = q[0];
    @(negedge clk);
    check("out_valid", out_valid, q.size() > 0);
    check("out_data", out_data, m_last);
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int stall_before;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    m_first = 1'b0;

    // Reset state while held low across clock edges.
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_in_ready", in_ready, 0);
    rst_n = 1'b1;
    m_first = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("stream_stall_zero", stall_cnt, 0);

    // Back-pressure: hold 0x00A5 for five stalled cycles, offering 0x005A meanwhile.
    step(1'b1, 16'h00A5, 1'b1, 1'b0);
    step(1'b1, 16'h005A, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h005A, 1'b0, 1'b0);
    check("stall_hold_data", out_data, 16'h00A5);
    check("stall_hold_valid", out_valid, 1);
    check("stall_five", stall_cnt, 5);
`ifdef PIPE_SKID_EN
    check("skid_full_in_ready", in_ready, 0);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush kills held entry and the payload offered in the same cycle.
    step(1'b1, 16'h0F0F, 1'b1, 1'b0);
    stall_before = int'(stall_cnt);
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    check("flush_valid", out_valid, 0);
    check("flush_stall_kept", stall_cnt, stall_before);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("flush_no_1234", out_data == 16'h1234, 0);

    // Stall counter saturation.
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("stall_saturated", stall_cnt, SAT);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while a payload is held.
    step(1'b1, 16'h3C3C, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_stall", stall_cnt, 0);
    check("async_rst_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    m_first = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_no_out", out_valid, 0);
    step(1'b1, 16'h7777, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 63) == 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
